// File: rtl/alu_exec.sv
// alu_exec: execute stage behind the 3x8-bit register group.
// Latches the source (s) and destination (d) operands on start, runs a
// single-cycle logic/arith op, a bit-serial shift or an 8-step shift-add
// multiply, then spends one WB cycle driving result with we low.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, op, s, d       request (sampled only in IDLE), opcode, operands
//   result, we            write-back data, active-low register write enable
//   busy, done            in-progress, one-cycle completion pulse (WB)
//   flag_c/z/n/v          condition flags, updated on EXEC->WB only
module alu_exec #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] result,
  output logic             we,
  output logic             busy,
  output logic             done,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_OR  = 3'b011, OP_XOR = 3'b100, OP_SHL = 3'b101,
                         OP_SHR = 3'b110, OP_MUL = 3'b111;

  logic [1:0]         state_q, state_d;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   s_q, d_q;
  // Work register: low half is the running result for all ops; the full
  // width holds the {partial product, multiplier} pair during MUL.
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               c_q, c_d, v_q, v_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d; // {c,z,n,v}

  logic [WIDTH:0]     sum, dif, msum;
  logic [SHW-1:0]     amt;

  assign amt  = s_q[SHW-1:0];
  assign sum  = {1'b0, d_q} + {1'b0, s_q};
  assign dif  = {1'b0, d_q} - {1'b0, s_q};
  assign msum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, d_q} : '0);

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    v_d      = v_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_EXEC;
        c_d     = 1'b0;
        v_d     = 1'b0;
        p_d     = (op == OP_MUL) ? {{WIDTH{1'b0}}, s} : {{WIDTH{1'b0}}, d};
        case (op)
          OP_SHL, OP_SHR: cnt_d = (s[SHW-1:0] == '0) ? CW'(1) : CW'(s[SHW-1:0]);
          OP_MUL:         cnt_d = CW'(WIDTH);
          default:        cnt_d = CW'(1);
        endcase
      end
      S_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          case (op_q)
            OP_ADD: begin
              p_d[WIDTH-1:0] = sum[WIDTH-1:0];
              c_d = sum[WIDTH];
              v_d = ~(d_q[WIDTH-1] ^ s_q[WIDTH-1]) & (d_q[WIDTH-1] ^ sum[WIDTH-1]);
            end
            OP_SUB: begin
              p_d[WIDTH-1:0] = dif[WIDTH-1:0];
              c_d = dif[WIDTH];  // borrow: d < s unsigned
              v_d = (d_q[WIDTH-1] ^ s_q[WIDTH-1]) & (d_q[WIDTH-1] ^ dif[WIDTH-1]);
            end
            OP_AND: p_d[WIDTH-1:0] = d_q & s_q;
            OP_OR:  p_d[WIDTH-1:0] = d_q | s_q;
            OP_XOR: p_d[WIDTH-1:0] = d_q ^ s_q;
            // Zero shift amount still burns one step but leaves d and C alone.
            OP_SHL: if (amt != '0) begin
              c_d = p_q[WIDTH-1];
              p_d[WIDTH-1:0] = {p_q[WIDTH-2:0], 1'b0};
            end
            OP_SHR: if (amt != '0) begin
              c_d = p_q[0];
              p_d[WIDTH-1:0] = {1'b0, p_q[WIDTH-1:1]};
            end
            default: p_d = {msum, p_q[WIDTH-1:1]}; // MUL shift-add step
          endcase
        end else begin
          state_d  = S_WB;
          result_d = p_q[WIDTH-1:0];
          flags_d[3] = (op_q == OP_MUL) ? (p_q[2*WIDTH-1:WIDTH] != '0) : c_q;
          flags_d[2] = (p_q[WIDTH-1:0] == '0);
          flags_d[1] = p_q[WIDTH-1];
          flags_d[0] = v_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      s_q      <= '0;
      d_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      v_q      <= v_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      if (state_q == S_IDLE && start) begin
        op_q <= op;
        s_q  <= s;
        d_q  <= d;
      end
    end
  end

  assign result = result_q;
  assign we     = (state_q != S_WB);
  assign done   = (state_q == S_WB);
  assign busy   = (state_q != S_IDLE);
  assign {flag_c, flag_z, flag_n, flag_v} = flags_q;
endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0] op = '0;
  logic [7:0] s = '0, d = '0, result;
  logic       we, busy, done, flag_c, flag_z, flag_n, flag_v;

  int n_chk = 0, n_fail = 0;

  alu_exec #(.WIDTH(8), .SHW(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .s(s), .d(d),
    .result(result), .we(we), .busy(busy), .done(done),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] d, s, r;
    logic [3:0] f;   // {c,z,n,v}
    int         lat; // edges after T0 at which WB is entered
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic from the operation rules.
  function automatic vec_t model(input logic [2:0] o, input logic [7:0] dd, input logic [7:0] ss);
    vec_t   v;
    int     k;
    int     full;
    logic   c, vv;
    logic [7:0] r;
    k = int'(ss[2:0]);
    c = 1'b0; vv = 1'b0;
    v.lat = 2;
    case (o)
      3'd0: begin full = int'(dd) + int'(ss); r = 8'(full); c = full > 255;
              vv = ($signed(dd) + $signed(ss) > 127) || ($signed(dd) + $signed(ss) < -128); end
      3'd1: begin r = dd - ss; c = dd < ss;
              vv = ($signed(dd) - $signed(ss) > 127) || ($signed(dd) - $signed(ss) < -128); end
      3'd2: r = dd & ss;
      3'd3: r = dd | ss;
      3'd4: r = dd ^ ss;
      3'd5: begin full = int'(dd) << k; r = 8'(full); c = (k > 0) && full[8];
              v.lat = (k > 0) ? k + 1 : 2; end
      3'd6: begin r = dd >> k; c = (k > 0) && dd[k-1]; v.lat = (k > 0) ? k + 1 : 2; end
      default: begin full = int'(dd) * int'(ss); r = 8'(full); c = full > 255; v.lat = 9; end
    endcase
    v.op = o; v.d = dd; v.s = ss; v.r = r;
    v.f = {c, r == 8'h00, r[7], vv};
    return v;
  endfunction

  // Issue one op and follow it through WB and back to IDLE.
  // pulse_at: edge index at which a stray start is presented (0 = none).
  task automatic run(input vec_t v, input string name, input int pulse_at);
    int lat;
    lat = 0;
    @(negedge clk);
    op = v.op; d = v.d; s = v.s; start = 1'b1;
    @(posedge clk); #1;                        // T0
    start = 1'b0;
    op = 3'($urandom); d = 8'($urandom); s = 8'($urandom);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      start = (n + 1 == pulse_at);
      if (!we) begin lat = n; break; end
    end
    start = 1'b0;
    chk({name, " latency"}, lat, v.lat);
    if (lat == 0) return;
    chk({name, " result"}, result, v.r);
    chk({name, " flags"}, {flag_c, flag_z, flag_n, flag_v}, v.f);
    chk({name, " wb done/busy"}, {done, busy}, 2'b11);
    @(posedge clk); #1;
    chk({name, " idle"}, {we, done, busy}, 3'b100);
    chk({name, " result held"}, result, v.r);
  endtask

  vec_t tbl[$];
  vec_t m;
  int   wb_cnt;

  initial begin
    tbl = '{
      '{3'd0, 8'h3C, 8'h03, 8'h3F, 4'b0000, 2},
      '{3'd1, 8'h03, 8'h3C, 8'hC7, 4'b1010, 2},
      '{3'd0, 8'h80, 8'h80, 8'h00, 4'b1101, 2},
      '{3'd5, 8'h03, 8'h05, 8'h60, 4'b0000, 6},
      '{3'd5, 8'h03, 8'h00, 8'h03, 4'b0000, 2},
      '{3'd6, 8'h03, 8'h01, 8'h01, 4'b1000, 2},
      '{3'd7, 8'h3C, 8'h03, 8'hB4, 4'b0010, 9},
      '{3'd2, 8'hF0, 8'h0F, 8'h00, 4'b0100, 2},
      '{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001, 2}
    };

    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {result, we, busy, done, flag_c, flag_z, flag_n, flag_v}, {8'h00, 7'b1000000});
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i), 0);

    // MUL with a stray start at T3: must be ignored, exactly one WB.
    run('{3'd7, 8'h80, 8'h03, 8'h80, 4'b1010, 9}, "mul_busy_start", 3);
    wb_cnt = 0;
    repeat (12) begin @(posedge clk); #1; if (!we) wb_cnt++; end
    chk("no queued op", wb_cnt, 0);

    // Reset during MUL: abort, no write.
    @(negedge clk); op = 3'd7; d = 8'hFF; s = 8'hFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;             // T0
    wb_cnt = 0;
    repeat (3) begin @(posedge clk); #1; if (!we) wb_cnt++; end
    rst_n = 1'b0; #1;                             // before T4
    chk("abort outputs", {result, we, busy, done, flag_c, flag_z, flag_n, flag_v}, {8'h00, 7'b1000000});
    repeat (12) begin @(posedge clk); #1; if (!we || done) wb_cnt++; end
    chk("abort no write", wb_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    run('{3'd0, 8'h01, 8'h01, 8'h02, 4'b0000, 2}, "add_after_reset", 0);

    // Randomized ops against the model.
    for (int i = 0; i < 40; i++) begin
      m = model(3'($urandom_range(7)), 8'($urandom), 8'($urandom));
      run(m, $sformatf("rnd%0d_op%0d", i, m.op), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
